// File: rtl/tick_feeder.sv
// rtl/tick_feeder.sv - paced replay of a stored price series from a sync-read ROM
module tick_feeder #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int PERIOD_WIDTH = 16,
    parameter int ROM_LATENCY  = 1,
    parameter int DROP_WIDTH   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    pause,
    input  logic [PERIOD_WIDTH-1:0] period,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [ADDR_WIDTH-1:0]   num_samples,
    input  logic                    loop_en,
    output logic                    mem_rd_en,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done,
    output logic [DROP_WIDTH-1:0]   drop_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [PERIOD_WIDTH-1:0] r_period;
    logic [PERIOD_WIDTH-1:0] r_counter;
    logic [ADDR_WIDTH-1:0]   r_base;
    logic [ADDR_WIDTH-1:0]   r_num;
    logic [ADDR_WIDTH-1:0]   r_idx;
    logic                    r_loop;
    logic [ROM_LATENCY-1:0]  r_pipe;
    logic [DATA_WIDTH-1:0]   r_out_data;
    logic                    r_out_valid;
    logic [DROP_WIDTH-1:0]   r_drop;
    logic                    w_start_ok;
    logic                    w_tick;
    logic                    w_last;
    logic                    w_emerge;

    // start is only honoured when no run is in progress
    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_tick     = (r_state == S_RUN) && !pause && (r_counter == r_period);
    assign w_last     = (r_idx == (r_num - ADDR_WIDTH'(1)));
    // the oldest pipeline tag marks the cycle mem_rdata belongs to a tick read
    assign w_emerge   = r_pipe[ROM_LATENCY-1];

    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign drop_count = r_drop;

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next-state logic plus read strobe and status outputs
    always_comb begin
        w_next    = r_state;
        mem_rd_en = w_tick;
        mem_addr  = '0;
        busy      = 1'b0;
        done      = 1'b0;
        if (w_tick) begin
            mem_addr = r_base + r_idx;
        end
        case (r_state)
            S_IDLE, S_DONE: begin
                done = (r_state == S_DONE);
                if (start) begin
                    w_next = (num_samples == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                // a stop coinciding with a tick still lets that read go out
                if (stop || (w_tick && w_last && !r_loop)) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (r_pipe == '0) begin
                    w_next = S_DONE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // run configuration, tick counter, read pipeline and output holding register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_period    <= '0;
            r_base      <= '0;
            r_num       <= '0;
            r_loop      <= 1'b0;
            r_counter   <= '0;
            r_idx       <= '0;
            r_pipe      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_drop      <= '0;
        end else begin
            if (w_start_ok) begin
                r_period  <= period;
                r_base    <= base_addr;
                r_num     <= num_samples;
                r_loop    <= loop_en;
                r_counter <= '0;
                r_idx     <= '0;
            end else if ((r_state == S_RUN) && !pause) begin
                if (w_tick) begin
                    r_counter <= '0;
                    if (!w_last) begin
                        r_idx <= r_idx + ADDR_WIDTH'(1);
                    end else if (r_loop) begin
                        r_idx <= '0;
                    end
                end else begin
                    r_counter <= r_counter + PERIOD_WIDTH'(1);
                end
            end

            r_pipe <= ROM_LATENCY'({r_pipe, w_tick});

            // latest price wins; an unaccepted sample being replaced counts as a drop
            if (w_emerge) begin
                r_out_data  <= mem_rdata;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_start_ok) begin
                r_drop <= '0;
            end else if (w_emerge && r_out_valid && !out_ready && (r_drop != '1)) begin
                r_drop <= r_drop + DROP_WIDTH'(1);
            end
        end
    end

endmodule
